// File: rtl/video_csc_pipelined.sv
// video_csc_pipelined: Avalon-ST colour-space converter with a 3-stage pipeline.
// Modes (latched on SOP): 0/3 passthrough, 1 YCrCb->RGB, 2 RGB->YCrCb (BT.601 full range).
// Stages: S1 capture/centre, S2 multiply, S3 sum/round/saturate into the output registers.
// All stages shift together on advance = ~stream_out_valid | stream_out_ready.
// Optional macro VIDEO_CSC_ALPHA_EN adds a fourth (alpha) channel that is only delayed.
module video_csc_pipelined #(
    parameter int CW      = 8,
    parameter int EW      = 1,
    parameter int COEF_FB = 10,
`ifdef VIDEO_CSC_ALPHA_EN
    localparam int NCH    = 4
`else
    localparam int NCH    = 3
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          mode_cfg,
    input  logic [NCH*CW-1:0]   stream_in_data,
    input  logic                stream_in_startofpacket,
    input  logic                stream_in_endofpacket,
    input  logic [EW:0]         stream_in_empty,
    input  logic                stream_in_valid,
    output logic                stream_in_ready,
    output logic [NCH*CW-1:0]   stream_out_data,
    output logic                stream_out_startofpacket,
    output logic                stream_out_endofpacket,
    output logic [EW:0]         stream_out_empty,
    output logic                stream_out_valid,
    input  logic                stream_out_ready
);

    localparam int DW = NCH * CW;
    localparam int IW = CW + COEF_FB + 4;

    // Q10 reference coefficients rescaled to COEF_FB fractional bits (round half away from zero).
    function automatic int rescale(input int c);
        if (COEF_FB >= 10)
            return c * (2 ** (COEF_FB - 10));
        else if (c >= 0)
            return (c + 2 ** (9 - COEF_FB)) / (2 ** (10 - COEF_FB));
        else
            return -((-c + 2 ** (9 - COEF_FB)) / (2 ** (10 - COEF_FB)));
    endfunction

    localparam logic signed [IW-1:0] K_Q    = IW'(2 ** COEF_FB);
    localparam logic signed [IW-1:0] K_HALF = IW'(2 ** (COEF_FB - 1));
    localparam logic signed [IW-1:0] K_OFS  = IW'(2 ** (CW - 1));
    localparam logic signed [IW-1:0] K_OFSQ = IW'(2 ** (CW - 1 + COEF_FB));
    localparam logic signed [IW-1:0] K_MAX  = IW'(2 ** CW - 1);
    localparam logic signed [IW-1:0] K_RV   = IW'(rescale(1436));
    localparam logic signed [IW-1:0] K_GU   = IW'(rescale(352));
    localparam logic signed [IW-1:0] K_GV   = IW'(rescale(731));
    localparam logic signed [IW-1:0] K_BU   = IW'(rescale(1815));
    localparam logic signed [IW-1:0] K_YR   = IW'(rescale(306));
    localparam logic signed [IW-1:0] K_YG   = IW'(rescale(601));
    localparam logic signed [IW-1:0] K_YB   = IW'(rescale(117));
    localparam logic signed [IW-1:0] K_CBR  = IW'(rescale(173));
    localparam logic signed [IW-1:0] K_CBG  = IW'(rescale(339));
    localparam logic signed [IW-1:0] K_C512 = IW'(rescale(512));
    localparam logic signed [IW-1:0] K_CRG  = IW'(rescale(429));
    localparam logic signed [IW-1:0] K_CRB  = IW'(rescale(83));

    logic                  advance;
    logic                  accept;
    logic [1:0]            mode_active;
    logic [1:0]            in_mode;
    logic signed [IW-1:0]  in_ch [3];

    logic                  s1_valid, s1_sop, s1_eop;
    logic [EW:0]           s1_empty;
    logic [1:0]            s1_mode;
    logic [DW-1:0]         s1_raw;
    logic signed [IW-1:0]  s1_ch [3];
    logic signed [IW-1:0]  coef [3][3];

    logic                  s2_valid, s2_sop, s2_eop;
    logic [EW:0]           s2_empty;
    logic [1:0]            s2_mode;
    logic [DW-1:0]         s2_raw;
    logic signed [IW-1:0]  s2_prod [3][3];

    logic signed [IW-1:0]  sum [3];
    logic signed [IW-1:0]  shr [3];
    logic [CW-1:0]         conv [3];
    logic [DW-1:0]         out_next;

    assign advance         = ~stream_out_valid | stream_out_ready;
    assign stream_in_ready = advance;
    assign accept          = stream_in_valid & advance;
    assign in_mode         = stream_in_startofpacket ? mode_cfg : mode_active;

    // Frame mode register: follows mode_cfg only on an accepted SOP beat.
    always_ff @(posedge clk) begin
        if (reset)
            mode_active <= 2'd0;
        else if (accept && stream_in_startofpacket)
            mode_active <= mode_cfg;
    end

    // Zero-extend input channels; chroma is centred around zero for YCrCb input.
    always_comb begin
        for (int j = 0; j < 3; j++) begin
            in_ch[j] = $signed({{(IW-CW){1'b0}}, stream_in_data[j*CW +: CW]});
            if (in_mode == 2'd1 && j != 0)
                in_ch[j] = in_ch[j] - K_OFS;
        end
    end

    // S1: capture beat, sideband and resolved mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sop   <= 1'b0;
            s1_eop   <= 1'b0;
            s1_empty <= '0;
            s1_mode  <= 2'd0;
            s1_raw   <= '0;
            for (int j = 0; j < 3; j++) s1_ch[j] <= '0;
        end else if (advance) begin
            s1_valid <= stream_in_valid;
            s1_sop   <= stream_in_startofpacket;
            s1_eop   <= stream_in_endofpacket;
            s1_empty <= stream_in_empty;
            s1_mode  <= in_mode;
            s1_raw   <= stream_in_data;
            for (int j = 0; j < 3; j++) s1_ch[j] <= in_ch[j];
        end
    end

    // Coefficient matrix for the S1 beat; rows are output channels, columns input channels.
    always_comb begin
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++)
                coef[k][j] = '0;
        case (s1_mode)
            2'd1: begin
                coef[0][0] = K_Q;  coef[0][1] = K_BU;
                coef[1][0] = K_Q;  coef[1][1] = -K_GU;  coef[1][2] = -K_GV;
                coef[2][0] = K_Q;  coef[2][2] = K_RV;
            end
            2'd2: begin
                coef[0][0] = K_YB;    coef[0][1] = K_YG;   coef[0][2] = K_YR;
                coef[1][0] = K_C512;  coef[1][1] = -K_CBG; coef[1][2] = -K_CBR;
                coef[2][0] = -K_CRB;  coef[2][1] = -K_CRG; coef[2][2] = K_C512;
            end
            default: ;
        endcase
    end

    // S2: nine partial products plus the delayed beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_sop   <= 1'b0;
            s2_eop   <= 1'b0;
            s2_empty <= '0;
            s2_mode  <= 2'd0;
            s2_raw   <= '0;
            for (int k = 0; k < 3; k++)
                for (int j = 0; j < 3; j++)
                    s2_prod[k][j] <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sop   <= s1_sop;
            s2_eop   <= s1_eop;
            s2_empty <= s1_empty;
            s2_mode  <= s1_mode;
            s2_raw   <= s1_raw;
            for (int k = 0; k < 3; k++)
                for (int j = 0; j < 3; j++)
                    s2_prod[k][j] <= coef[k][j] * s1_ch[j];
        end
    end

    // S3 datapath: sum, chroma offset, round, arithmetic shift, clamp to [0, 2^CW-1].
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            sum[k] = s2_prod[k][0] + s2_prod[k][1] + s2_prod[k][2] + K_HALF;
            if (s2_mode == 2'd2 && k != 0)
                sum[k] = sum[k] + K_OFSQ;
            shr[k] = sum[k] >>> COEF_FB;
            if (shr[k] < 0)
                conv[k] = '0;
            else if (shr[k] > K_MAX)
                conv[k] = '1;
            else
                conv[k] = shr[k][CW-1:0];
        end
        // Any channel above the three colour channels (alpha) stays raw.
        out_next = s2_raw;
        if (s2_mode == 2'd1 || s2_mode == 2'd2)
            out_next[3*CW-1:0] = {conv[2], conv[1], conv[0]};
    end

    // S3: output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stream_out_valid         <= 1'b0;
            stream_out_data          <= '0;
            stream_out_startofpacket <= 1'b0;
            stream_out_endofpacket   <= 1'b0;
            stream_out_empty         <= '0;
        end else if (advance) begin
            stream_out_valid         <= s2_valid;
            stream_out_data          <= out_next;
            stream_out_startofpacket <= s2_sop;
            stream_out_endofpacket   <= s2_eop;
            stream_out_empty         <= s2_empty;
        end
    end

endmodule

// File: tb/tb_video_csc_pipelined.sv
// Testbench for video_csc_pipelined: directed vector table, scoreboard with a
// reference model, backpressure, throughput and reset-in-flight sequences.
module tb_video_csc_pipelined;

    localparam int CW = 8;
    localparam int EW = 1;
`ifdef VIDEO_CSC_ALPHA_EN
    localparam int NCH = 4;
`else
    localparam int NCH = 3;
`endif
    localparam int DW = NCH * CW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    mode_cfg;
    logic [DW-1:0] stream_in_data;
    logic          stream_in_startofpacket, stream_in_endofpacket;
    logic [EW:0]   stream_in_empty;
    logic          stream_in_valid;
    logic          stream_in_ready;
    logic [DW-1:0] stream_out_data;
    logic          stream_out_startofpacket, stream_out_endofpacket;
    logic [EW:0]   stream_out_empty;
    logic          stream_out_valid;
    logic          stream_out_ready;

    always #5 clk = ~clk;

    video_csc_pipelined #(.CW(CW), .EW(EW), .COEF_FB(10)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .mode_cfg                 (mode_cfg),
        .stream_in_data           (stream_in_data),
        .stream_in_startofpacket  (stream_in_startofpacket),
        .stream_in_endofpacket    (stream_in_endofpacket),
        .stream_in_empty          (stream_in_empty),
        .stream_in_valid          (stream_in_valid),
        .stream_in_ready          (stream_in_ready),
        .stream_out_data          (stream_out_data),
        .stream_out_startofpacket (stream_out_startofpacket),
        .stream_out_endofpacket   (stream_out_endofpacket),
        .stream_out_empty         (stream_out_empty),
        .stream_out_valid         (stream_out_valid),
        .stream_out_ready         (stream_out_ready)
    );

    int ncmp = 0;
    int nfail = 0;
    int cnt_ov = 0;
    bit bp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        if (v < 0) return 0;
        if (v > (1 << CW) - 1) return (1 << CW) - 1;
        return v;
    endfunction

    // BT.601 full-range conversion from the coefficient equations, plain integer arithmetic.
    function automatic logic [DW-1:0] ref_conv(input logic [1:0] m, input logic [DW-1:0] d);
        int c0, c1, c2, o0, o1, o2, ofs;
        logic [DW-1:0] r;
        ofs = 1 << (CW - 1);
        c0 = int'(d[CW-1:0]);
        c1 = int'(d[2*CW-1:CW]);
        c2 = int'(d[3*CW-1:2*CW]);
        r = d;
        if (m == 2'd1) begin
            o0 = sat((c0 * 1024 + 1815 * (c1 - ofs) + 512) >>> 10);
            o1 = sat((c0 * 1024 - 352 * (c1 - ofs) - 731 * (c2 - ofs) + 512) >>> 10);
            o2 = sat((c0 * 1024 + 1436 * (c2 - ofs) + 512) >>> 10);
            r[CW-1:0] = CW'(o0); r[2*CW-1:CW] = CW'(o1); r[3*CW-1:2*CW] = CW'(o2);
        end else if (m == 2'd2) begin
            o0 = sat((117 * c0 + 601 * c1 + 306 * c2 + 512) >>> 10);
            o1 = sat((512 * c0 - 339 * c1 - 173 * c2 + ofs * 1024 + 512) >>> 10);
            o2 = sat((-83 * c0 - 429 * c1 + 512 * c2 + ofs * 1024 + 512) >>> 10);
            r[CW-1:0] = CW'(o0); r[2*CW-1:CW] = CW'(o1); r[3*CW-1:2*CW] = CW'(o2);
        end
        return r;
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW:0]   empty;
    } exp_t;

    exp_t sb[$];
    logic [1:0] model_mode = 2'd0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [EW+2:0] prev_ctl;

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        exp_t e, g;
        logic [1:0] m;
        if (reset) begin
            sb.delete();
            model_mode = 2'd0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", stream_out_valid, 1'b1);
                check("hold_data", stream_out_data, prev_data);
                check("hold_ctl", {stream_out_startofpacket, stream_out_endofpacket, stream_out_empty}, prev_ctl);
            end
            if (stream_in_valid && stream_in_ready) begin
                m = stream_in_startofpacket ? mode_cfg : model_mode;
                if (stream_in_startofpacket) model_mode = mode_cfg;
                e.data  = ref_conv(m, stream_in_data);
                e.sop   = stream_in_startofpacket;
                e.eop   = stream_in_endofpacket;
                e.empty = stream_in_empty;
                sb.push_back(e);
            end
            if (stream_out_valid && stream_out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_beat", stream_out_data, '0);
                    if (stream_out_data == '0) begin
                        nfail++;
                        $display("FAIL sb_unexpected_beat: output beat with empty scoreboard at %0t", $time);
                    end
                end else begin
                    g = sb.pop_front();
                    check("sb_data", stream_out_data, g.data);
                    check("sb_ctl", {stream_out_startofpacket, stream_out_endofpacket, stream_out_empty},
                          {g.sop, g.eop, g.empty});
                end
            end
            prev_stall = stream_out_valid && !stream_out_ready;
            prev_data  = stream_out_data;
            prev_ctl   = {stream_out_startofpacket, stream_out_endofpacket, stream_out_empty};
        end
        if (stream_out_valid) cnt_ov++;
    end

    // Random downstream backpressure.
    always @(posedge clk) begin
        #1;
        if (bp_en) stream_out_ready = ($urandom_range(0, 1) == 1);
    end

    // Present a beat and hold it until accepted; returns the number of cycles taken.
    task automatic send(input logic [1:0] m, input logic s, input logic e, input logic [EW:0] em,
                        input logic [DW-1:0] d, output int waited);
        bit acc;
        stream_in_valid = 1'b1;
        stream_in_startofpacket = s;
        stream_in_endofpacket = e;
        stream_in_empty = em;
        stream_in_data = d;
        mode_cfg = m;
        waited = 0;
        do begin
            @(negedge clk);
            acc = stream_in_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!acc && waited < 500);
        if (!acc) begin
            ncmp++;
            nfail++;
            $display("FAIL send_timeout: beat not accepted after %0d cycles", waited);
        end
    endtask

    task automatic idle();
        stream_in_valid = 1'b0;
        stream_in_startofpacket = 1'b0;
        stream_in_endofpacket = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    typedef struct {
        logic [1:0]    mode;
        logic          sop;
        logic [DW-1:0] din;
        logic [DW-1:0] dexp;
    } vec_t;

    localparam int NV = 7;
    vec_t vt [NV];

    initial begin
        int w;
        logic [DW-1:0] d;
        logic [EW:0] em;
        int len, b;

        vt[0] = '{2'd1, 1'b1, DW'(24'h808080), DW'(24'h808080)};
        vt[1] = '{2'd1, 1'b1, DW'(24'hFF80FF), DW'(24'hFFA4FF)};
        vt[2] = '{2'd2, 1'b0, DW'(24'hFFFF00), DW'(24'hB200E1)};
        vt[3] = '{2'd2, 1'b1, DW'(24'hFF0000), DW'(24'hFF554C)};
        vt[4] = '{2'd0, 1'b1, DW'(24'hA5C3E1), DW'(24'hA5C3E1)};
        vt[5] = '{2'd3, 1'b1, DW'(24'h123456), DW'(24'h123456)};
        vt[6] = '{2'd1, 1'b1, DW'(24'h808000), DW'(24'h000000)};

        mode_cfg = 2'd0;
        stream_in_data = '0;
        stream_in_empty = '0;
        idle();
        stream_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", stream_out_valid, 1'b0);
        check("rst_data", stream_out_data, '0);
        check("rst_ctl", {stream_out_startofpacket, stream_out_endofpacket, stream_out_empty}, '0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", stream_in_ready, 1'b1);

        // Directed vectors, one isolated beat each, exact 3-cycle latency.
        for (int i = 0; i < NV; i++) begin
            stream_in_valid = 1'b1;
            stream_in_startofpacket = vt[i].sop;
            stream_in_endofpacket = 1'b0;
            stream_in_empty = '0;
            stream_in_data = vt[i].din;
            mode_cfg = vt[i].mode;
            @(posedge clk); #1;
            idle();
            @(posedge clk); #1;
            check("vec_early_valid", stream_out_valid, 1'b0);
            @(posedge clk); #1;
            check("vec_valid", stream_out_valid, 1'b1);
            check("vec_data", stream_out_data, vt[i].dexp);
            check("vec_sop", stream_out_startofpacket, vt[i].sop);
            @(posedge clk); #1;
        end
        drain();

        // Mid-frame mode change is ignored until the next SOP.
        send(2'd1, 1'b1, 1'b0, 2'd0, DW'($urandom), w);
        send(2'd2, 1'b0, 1'b0, 2'd0, DW'($urandom), w);
        send(2'd2, 1'b0, 1'b0, 2'd0, DW'($urandom), w);
        send(2'd2, 1'b0, 1'b1, 2'd1, DW'($urandom), w);
        send(2'd2, 1'b1, 1'b1, 2'd0, DW'($urandom), w);
        idle();
        drain();

        // Throughput with ready held high: one beat per cycle in and out.
        repeat (2) @(posedge clk);
        #1;
        cnt_ov = 0;
        for (int i = 0; i < 20; i++) begin
            send(2'(i % 3), i == 0, i == 19, 2'd0, DW'($urandom), w);
            check("tput_accept_cycles", w, 1);
        end
        idle();
        repeat (5) @(posedge clk);
        #1;
        check("tput_out_count", cnt_ov, 20);
        drain();

        // Random frames under 50% backpressure.
        bp_en = 1'b1;
        b = 0;
        while (b < 1000) begin
            len = $urandom_range(1, 8);
            for (int k = 0; k < len && b < 1000; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    idle();
                    stream_in_data = DW'($urandom);
                    @(posedge clk); #1;
                end
                em = 2'($urandom_range(0, 3));
                d = DW'($urandom);
                send(2'($urandom_range(0, 3)), k == 0, k == len - 1, em, d, w);
                b++;
            end
        end
        idle();
        bp_en = 1'b0;
        @(posedge clk); #1;
        stream_out_ready = 1'b1;
        drain();

        // Reset with three beats in flight.
        send(2'd1, 1'b1, 1'b0, 2'd1, DW'($urandom), w);
        send(2'd1, 1'b0, 1'b0, 2'd2, DW'($urandom), w);
        send(2'd1, 1'b0, 1'b0, 2'd3, DW'($urandom), w);
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", stream_out_valid, 1'b0);
        check("midrst_data", stream_out_data, '0);
        check("midrst_ctl", {stream_out_startofpacket, stream_out_endofpacket, stream_out_empty}, '0);
        reset = 1'b0;
        check("midrst_ready", stream_in_ready, 1'b1);
        d = DW'($urandom);
        send(2'd1, 1'b0, 1'b0, 2'd0, d, w);
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("postrst_valid", stream_out_valid, 1'b1);
        check("postrst_passthrough", stream_out_data, d);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #1000000;
        nfail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
